// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the neuron MAC element.
// Helpers work on a wide signed carrier so any legal N/GUARD fits without overflow.
package neuron_pkg;

  localparam int MAXW = 128;
  typedef logic signed [MAXW-1:0] wide_t;

  localparam int N_DEFAULT     = 8;
  localparam int GUARD_DEFAULT = 8;

  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

  localparam int ACC_W_DEFAULT = acc_width(N_DEFAULT, GUARD_DEFAULT);

  // Signed add clamped to the range of a width-bit two's complement value.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = a + b;
    hi  = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    if (sum > hi)
      return hi;
    else if (sum < lo)
      return lo;
    else
      return sum;
  endfunction

  // ReLU followed by a clamp to the largest positive n-bit signed value.
  function automatic wide_t relu_sat(input wide_t s, input int n);
    wide_t hi;
    hi = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
    if (s < 0)
      return '0;
    else if (s > hi)
      return hi;
    else
      return s;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Signed multiplier feeding a saturating accumulator register.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N     = 8,
  parameter int GUARD = 8,
  parameter int ACC_W = acc_width(N, GUARD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [N-1:0]     w,
  input  logic signed [N-1:0]     x,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*N-1:0] prod;

  always_comb begin
    prod = w * x;
  end

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= ACC_W'(sat_add(wide_t'(acc), wide_t'(prod), ACC_W));
  end

endmodule

// File: rtl/neuron_nbits.sv
// Single neuron: MAC accumulator, rescale by N bits, saturating ReLU output.
module neuron_nbits
  import neuron_pkg::*;
#(
  parameter int N     = 8,
  parameter int GUARD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] W,
  input  logic signed [N-1:0] X,
  output logic signed [N-1:0] Out
);

  localparam int ACC_W = acc_width(N, GUARD);

  logic signed [ACC_W-1:0] acc;
  wide_t                   scaled;

  neuron_mac #(
    .N     (N),
    .GUARD (GUARD),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .w   (W),
    .x   (X),
    .acc (acc)
  );

  always_comb begin
    scaled = wide_t'(acc) >>> N;
    Out    = N'(relu_sat(scaled, N));
  end

endmodule

// File: tb/tb_neuron_nbits.sv
// Scoreboard bench for neuron_nbits: driver pushes expected results, monitor compares.
module tb_neuron_nbits;

  localparam int N     = 8;
  localparam int GUARD = 8;
  localparam int ACC_W = 2 * N + GUARD;

  logic                clk;
  logic                rst;
  logic                en;
  logic signed [N-1:0] W;
  logic signed [N-1:0] X;
  logic signed [N-1:0] Out;

  neuron_nbits #(
    .N     (N),
    .GUARD (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .W   (W),
    .X   (X),
    .Out (Out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    longint exp_out;
    longint exp_acc;
    string  tag;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  longint model_acc = 0;

  // Reference model: plain integer arithmetic on the accumulator value.
  function automatic longint clamp_acc(input longint v);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (ACC_W - 1)) - 1;
    lo = -(64'sd1 <<< (ACC_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint out_of(input longint a);
    longint s;
    longint hi;
    s  = a >>> N;
    hi = (64'sd1 <<< (N - 1)) - 1;
    if (s < 0) return 0;
    if (s > hi) return hi;
    return s;
  endfunction

  // Drive one cycle at the negedge; want_out >= 0 overrides the model's output expectation.
  task automatic step(input logic r, input logic e, input int wv, input int xv,
                      input longint want_out, input string tag);
    exp_t ex;
    rst = r;
    en  = e;
    W   = N'(wv);
    X   = N'(xv);
    if (r)
      model_acc = 0;
    else if (e)
      model_acc = clamp_acc(model_acc + longint'(W) * longint'(X));
    ex.exp_out = (want_out >= 0) ? want_out : out_of(model_acc);
    ex.exp_acc = model_acc;
    ex.tag     = tag;
    sb_q.push_back(ex);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t                    ex;
    logic signed [ACC_W-1:0] e_acc;
    logic signed [63:0]      tmp;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        ex    = sb_q.pop_front();
        tmp   = ex.exp_acc;
        e_acc = tmp[ACC_W-1:0];
        checks++;
        if (Out !== N'(ex.exp_out)) begin
          errors++;
          $display("FAIL %s out: got %0d expected %0d at %0t", ex.tag, Out, ex.exp_out, $time);
        end
        checks++;
        if (dut.u_mac.acc !== e_acc) begin
          errors++;
          $display("FAIL %s acc: got %0d expected %0d at %0t", ex.tag, dut.u_mac.acc, e_acc, $time);
        end
      end
    end
  end

  initial begin : driver
    int r_w;
    int r_x;
    rst = 1'b1;
    en  = 1'b0;
    W   = '0;
    X   = '0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, "reset");
    step(0, 1, -3, 2, 0, "neg_sum1");
    step(0, 1, 5, -4, 0, "neg_sum2");
    step(1, 1, 0, 0, 0, "mid_reset");
    step(0, 1, 0, 0, 0, "zero_mac");
    step(0, 1, 64, 2, 0, "thresh1");
    step(0, 1, 64, 2, 1, "thresh2");
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 8, 4, 1, "hold");
    step(0, 1, 127, 127, 64, "osat1");
    step(0, 1, 127, 127, 127, "osat2");
    for (int unsigned i = 0; i < 8; i++) step(0, 1, 127, 127, 127, "osat");
    for (int unsigned i = 0; i < 12; i++) step(0, 1, -128, 127, -1, "odrop");
    step(0, 1, -128, 127, 0, "odrop_neg");
    for (int unsigned i = 0; i < 540; i++) step(0, 1, -128, -128, -1, "acc_pos_sat");
    step(0, 1, -128, -128, 127, "acc_pos_hold");
    step(1, 0, 0, 0, 0, "reset2");
    for (int unsigned i = 0; i < 540; i++) step(0, 1, -128, 127, 0, "acc_neg_sat");
    step(0, 1, 127, 127, 0, "acc_neg_recover");
    step(1, 0, 0, 0, 0, "reset3");

    for (int unsigned i = 0; i < 600; i++) begin
      r_w = int'($urandom_range(255, 0)) - 128;
      r_x = int'($urandom_range(255, 0)) - 128;
      step(($urandom_range(31, 0) == 0), ($urandom_range(3, 0) != 0), r_w, r_x, -1, "rand");
    end

    for (int unsigned i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
